gaussian_blur_bram: RTL
=======================

# gaussian_blur_bram

Applies a 3x3 Gaussian blur to a WIDTH x HEIGHT 8-bit grayscale image held in a single-port BRAM and writes the result, same size, to a second BRAM. It is the stage directly upstream of the 2x image downsampler in the SIFT octave pipeline: it blurs the base image before the downsampler halves it. Pixels are processed one at a time in raster order, with edge pixels replicated.

## Interface

Parameters:
- BIT_DEPTH, 8: pixel width.
- WIDTH, 64: image width in pixels.
- HEIGHT, 64: image height in pixels.
- READ_LATENCY, 2: source BRAM cycles from address to data (2 = HIGH_PERFORMANCE).

Ports (reset is asynchronous and active-low):
- clk_in, input, 1: single clock.
- rst_n_in, input, 1: asynchronous active-low reset.
- start_in, input, 1: starts a full-image pass; sampled only in IDLE.
- ext_read_addr, output, $clog2(WIDTH*HEIGHT): source address, y*WIDTH+x.
- ext_read_addr_valid, output, 1: source BRAM enable.
- ext_pixel_in, input, BIT_DEPTH: source BRAM data.
- ext_write_addr, output, $clog2(WIDTH*HEIGHT): destination address.
- ext_write_valid, output, 1: destination write enable, 1-cycle strobe per pixel.
- ext_pixel_out, output, BIT_DEPTH: blurred pixel.
- center_addr_x_used, output, $clog2(WIDTH): x coordinate of the current center pixel (debug).
- center_addr_y_used, output, $clog2(HEIGHT): y coordinate of the current center pixel (debug).
- busy, output, 1: high from the first READ cycle through the final WRITE.
- blur_done, output, 1: 1-cycle pulse after the last pixel is written.

## Operation

- Kernel: [1 2 1; 2 4 2; 1 2 1].
- Output = (sum + 8) >> 4, computed in a 12-bit accumulator. The maximum value is (4080+8)>>4 = 255, so no saturation is needed.
- Taps are issued in row-major order: dy = -1, 0, +1 (outer loop), then dx = -1, 0, +1 (inner loop).
- Edge handling clamps coordinates: x-1 at x=0 becomes 0, x+1 at WIDTH-1 becomes WIDTH-1, and y is treated the same way.
- FSM states:
  - IDLE → READ when start_in = 1.
  - READ: 9 cycles, one tap address per cycle, then → WAIT.
  - WAIT: READ_LATENCY cycles, then → WRITE.
  - WRITE: 1 cycle. If the last pixel was written → DONE; otherwise advance the center pixel (x first, then y) and go → READ.
  - DONE: 1 cycle, blur_done = 1, then → IDLE.
- A weight/valid shift register of depth READ_LATENCY tags each returning datum. ext_pixel_in is accumulated in the cycle its tag emerges.
- The accumulator clears on entry to READ.
- ext_read_addr_valid is high in READ and WAIT. During WAIT, ext_read_addr holds the last tap address so the BRAM output register keeps advancing.
- start_in is ignored outside IDLE.
- A new pass after DONE starts cleanly from pixel (0,0).

## Timing

- Let cycle 0 be the first READ cycle, which is the cycle after start_in is sampled high in IDLE.
- Per-pixel period T = 10 + READ_LATENCY (12 by default).
- Pixel n: tap k is addressed at cycle n*T + k, and its data is used at n*T + k + READ_LATENCY.
- WRITE for pixel n occurs at cycle n*T + 9 + READ_LATENCY. ext_write_addr = n, and ext_pixel_out is valid in that same cycle.
- blur_done pulses at cycle WIDTH*HEIGHT*T; busy falls in that same cycle.
- Total pass time at defaults: 49152 cycles.
- Reset values of all outputs are 0, including addresses, valids, pixel_out, busy, blur_done and the center coordinates. State resets to IDLE.
- Asserting rst_n_in mid-pass aborts immediately: no further writes occur and no blur_done pulse is issued. A subsequent start_in restarts from pixel 0.
- ext_write_valid is never high in two consecutive cycles.
- ext_write_addr increases monotonically from 0 to WIDTH*HEIGHT-1 with no gaps.

## Test plan

- Constant image of 100 → all 4096 outputs are 100. Exactly 4096 write strobes occur, and blur_done rises at cycle 49152.
- Impulse of 255 at (10,10), all other pixels 0 → outputs are:
  - (10,10) = 64
  - (9,10), (11,10), (10,9), (10,11) = 32
  - the four diagonal neighbours = 16
  - all other pixels = 0
- Corner clamp: only pixel (0,0) = 160 → output (0,0) = (160*9+8)>>4 = 90. Output (63,63) = 0.
- Latency check with READ_LATENCY=2: first ext_write_valid at cycle 11 with ext_write_addr = 0. Second write at cycle 23 with ext_write_addr = 1. Read addresses for pixel 0 are 0,0,1,0,0,1,64,64,65.
- Pulse start_in at cycle 100 while busy → ignored: write sequence and blur_done timing are unchanged. A start_in one cycle after blur_done begins a new pass from address 0.
- Drive rst_n_in low at cycle 5000 → all outputs are 0 within the same cycle and no blur_done follows. Release reset, pulse start_in → a full correct pass completes.

Source files
------------

// File: rtl/gaussian_blur_bram.sv
// 3x3 Gaussian blur between two BRAMs: nine clamped tap reads per pixel, tagged
// on return, accumulated and rounded; one output pixel every 10 + READ_LATENCY cycles.
module gaussian_blur_bram #(
  parameter int BIT_DEPTH    = 8,
  parameter int WIDTH        = 64,
  parameter int HEIGHT       = 64,
  parameter int READ_LATENCY = 2
) (
  input  logic                            clk_in,
  input  logic                            rst_n_in,
  input  logic                            start_in,
  output logic [$clog2(WIDTH*HEIGHT)-1:0] ext_read_addr,
  output logic                            ext_read_addr_valid,
  input  logic [BIT_DEPTH-1:0]            ext_pixel_in,
  output logic [$clog2(WIDTH*HEIGHT)-1:0] ext_write_addr,
  output logic                            ext_write_valid,
  output logic [BIT_DEPTH-1:0]            ext_pixel_out,
  output logic [$clog2(WIDTH)-1:0]        center_addr_x_used,
  output logic [$clog2(HEIGHT)-1:0]       center_addr_y_used,
  output logic                            busy,
  output logic                            blur_done
);
  localparam int AW    = $clog2(WIDTH*HEIGHT);
  localparam int XW    = $clog2(WIDTH);
  localparam int YW    = $clog2(HEIGHT);
  localparam int ACC_W = BIT_DEPTH + 4;
  localparam int WTW   = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state, w_next_state;
  logic [3:0]       r_tap, w_tap_next;
  logic [WTW-1:0]   r_wait, w_wait_next;
  logic [XW-1:0]    w_cx_next;
  logic [YW-1:0]    w_cy_next;
  logic [AW-1:0]    r_pix, w_pix_next;
  logic [ACC_W-1:0] r_acc, w_acc_next, w_acc_rnd;
  logic [3:0]       r_tag [READ_LATENCY];
  logic [3:0]       w_tag_in, w_tag_out;
  logic [AW-1:0]    w_read_addr_next, w_write_addr_next;
  logic [BIT_DEPTH-1:0] w_pixel_out_next;
  logic             w_read_valid_next, w_write_valid_next, w_busy_next, w_done_next;

  function automatic logic [2:0] tap_weight(input logic [3:0] tap);
    case (tap)
      4'd4:                   return 3'd4;
      4'd1, 4'd3, 4'd5, 4'd7: return 3'd2;
      default:                return 3'd1;
    endcase
  endfunction

  // Tap k of center (cx,cy): row k/3, column k%3, coordinates clamped to the image.
  function automatic logic [AW-1:0] tap_addr(input logic [3:0] tap, input logic [XW-1:0] cx,
                                             input logic [YW-1:0] cy);
    logic [1:0] row, col;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    case (tap)
      4'd0, 4'd1, 4'd2: row = 2'd0;
      4'd3, 4'd4, 4'd5: row = 2'd1;
      default:          row = 2'd2;
    endcase
    case (tap)
      4'd0, 4'd3, 4'd6: col = 2'd0;
      4'd1, 4'd4, 4'd7: col = 2'd1;
      default:          col = 2'd2;
    endcase
    case (col)
      2'd0:    x = (cx == XW'(0)) ? cx : cx - XW'(1);
      2'd1:    x = cx;
      default: x = (cx == XW'(WIDTH - 1)) ? cx : cx + XW'(1);
    endcase
    case (row)
      2'd0:    y = (cy == YW'(0)) ? cy : cy - YW'(1);
      2'd1:    y = cy;
      default: y = (cy == YW'(HEIGHT - 1)) ? cy : cy + YW'(1);
    endcase
    return (AW'(y) * AW'(WIDTH)) + AW'(x);
  endfunction

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= S_IDLE;
    else           r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  w_next_state = start_in ? S_READ : S_IDLE;
      S_READ:  w_next_state = (r_tap == 4'd8) ? S_WAIT : S_READ;
      S_WAIT:  w_next_state = (r_wait == WTW'(READ_LATENCY - 1)) ? S_WRITE : S_WAIT;
      S_WRITE: w_next_state = (r_pix == AW'(WIDTH*HEIGHT - 1)) ? S_DONE : S_READ;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Tap/wait counters and center-pixel advance (x first, then y).
  always_comb begin
    w_tap_next  = r_tap;
    w_wait_next = r_wait;
    w_cx_next   = center_addr_x_used;
    w_cy_next   = center_addr_y_used;
    w_pix_next  = r_pix;
    case (r_state)
      S_IDLE: begin
        w_tap_next  = 4'd0;
        w_wait_next = WTW'(0);
        if (start_in) begin
          w_cx_next  = XW'(0);
          w_cy_next  = YW'(0);
          w_pix_next = AW'(0);
        end else begin
          w_pix_next = r_pix;
        end
      end
      S_READ: begin
        if (r_tap == 4'd8) begin
          w_wait_next = WTW'(0);
        end else begin
          w_tap_next = r_tap + 4'd1;
        end
      end
      S_WAIT: w_wait_next = (r_wait == WTW'(READ_LATENCY - 1)) ? WTW'(0) : r_wait + WTW'(1);
      S_WRITE: begin
        w_tap_next = 4'd0;
        if (r_pix != AW'(WIDTH*HEIGHT - 1)) begin
          w_pix_next = r_pix + AW'(1);
          if (center_addr_x_used == XW'(WIDTH - 1)) begin
            w_cx_next = XW'(0);
            w_cy_next = center_addr_y_used + YW'(1);
          end else begin
            w_cx_next = center_addr_x_used + XW'(1);
          end
        end else begin
          w_pix_next = r_pix;
        end
      end
      default: w_tap_next = r_tap;
    endcase
  end

  // Accumulate each returning datum with the weight tagged when it was addressed.
  always_comb begin
    w_tag_in  = (r_state == S_READ) ? {1'b1, tap_weight(r_tap)} : 4'd0;
    w_tag_out = r_tag[READ_LATENCY-1];
    if ((w_next_state == S_READ) && (r_state != S_READ)) begin
      w_acc_next = ACC_W'(0);
    end else if (w_tag_out[3]) begin
      w_acc_next = r_acc + ACC_W'(ext_pixel_in) * ACC_W'(w_tag_out[2:0]);
    end else begin
      w_acc_next = r_acc;
    end
    w_acc_rnd = w_acc_next + ACC_W'(8);
  end

  // Output logic: next values for the registered outputs.
  always_comb begin
    w_read_valid_next  = (w_next_state == S_READ) || (w_next_state == S_WAIT);
    w_write_valid_next = (w_next_state == S_WRITE);
    w_busy_next        = (w_next_state == S_READ) || (w_next_state == S_WAIT) ||
                         (w_next_state == S_WRITE);
    w_done_next        = (w_next_state == S_DONE);
    if (w_next_state == S_READ) begin
      w_read_addr_next = tap_addr(w_tap_next, w_cx_next, w_cy_next);
    end else if (w_next_state == S_WAIT) begin
      w_read_addr_next = ext_read_addr;
    end else begin
      w_read_addr_next = AW'(0);
    end
    if (w_next_state == S_WRITE) begin
      w_write_addr_next = r_pix;
      w_pixel_out_next  = BIT_DEPTH'(w_acc_rnd >> 4);
    end else begin
      w_write_addr_next = ext_write_addr;
      w_pixel_out_next  = ext_pixel_out;
    end
  end

  // Weight/valid tag pipeline, aligned with the source BRAM latency.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < READ_LATENCY; i++) r_tag[i] <= 4'd0;
    end else begin
      r_tag[0] <= w_tag_in;
      for (int i = 1; i < READ_LATENCY; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_tap               <= 4'd0;
      r_wait              <= WTW'(0);
      r_pix               <= AW'(0);
      r_acc               <= ACC_W'(0);
      center_addr_x_used  <= XW'(0);
      center_addr_y_used  <= YW'(0);
      ext_read_addr       <= AW'(0);
      ext_read_addr_valid <= 1'b0;
      ext_write_addr      <= AW'(0);
      ext_write_valid     <= 1'b0;
      ext_pixel_out       <= BIT_DEPTH'(0);
      busy                <= 1'b0;
      blur_done           <= 1'b0;
    end else begin
      r_tap               <= w_tap_next;
      r_wait              <= w_wait_next;
      r_pix               <= w_pix_next;
      r_acc               <= w_acc_next;
      center_addr_x_used  <= w_cx_next;
      center_addr_y_used  <= w_cy_next;
      ext_read_addr       <= w_read_addr_next;
      ext_read_addr_valid <= w_read_valid_next;
      ext_write_addr      <= w_write_addr_next;
      ext_write_valid     <= w_write_valid_next;
      ext_pixel_out       <= w_pixel_out_next;
      busy                <= w_busy_next;
      blur_done           <= w_done_next;
    end
  end
endmodule
